// File: rtl/accel_ramp_multi.sv
// Multi-channel motor command ramp: on each prescaler tick every channel's
// speed/direction word steps toward its target, with an emergency-stop override.
module accel_ramp_multi #(
    parameter int unsigned N_CH       = 2,
    parameter int unsigned SPEED_W    = 3,
    parameter int unsigned TICK_DIV   = 8800000,
    parameter int unsigned STEP       = 1,
    parameter int unsigned STEP_ESTOP = 2
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [N_CH*(SPEED_W+2)-1:0]   DESIRED_MC,
    input  logic                          ESTOP,
    output logic [N_CH*(SPEED_W+2)-1:0]   MCP,
    output logic [N_CH-1:0]               SETTLED,
    output logic                          TICK
);

    localparam int unsigned W     = SPEED_W + 2;
    localparam int unsigned SW1   = SPEED_W + 1;
    localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0]         NEUTRAL = 2'b01;
    localparam logic [SPEED_W-1:0] ONES    = '1;
    localparam logic [W-1:0]       REST    = {ONES, NEUTRAL};
    localparam logic [SPEED_W:0]   STEP_N  = SW1'(STEP);
    localparam logic [SPEED_W:0]   STEP_E  = SW1'(STEP_ESTOP);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0]          cnt;
    logic                      wrap;
    logic [N_CH-1:0][W-1:0]    desired;
    logic [N_CH-1:0][W-1:0]    mcp_q;
    logic [N_CH-1:0][W-1:0]    tgt;
    logic [N_CH-1:0][W-1:0]    nxt;
    logic [N_CH-1:0]           stl;
    logic [SPEED_W:0]          step_sel;

    // One ramp step: reversals always pass through neutral at rest speed.
    function automatic logic [W-1:0] ramp(input logic [W-1:0] cur,
                                          input logic [W-1:0] target,
                                          input logic [SPEED_W:0] step);
        logic [SPEED_W-1:0] cs;
        logic [SPEED_W-1:0] ts;
        logic [1:0]         cd;
        logic [1:0]         td;
        logic [SPEED_W:0]   diff;
        logic [SPEED_W:0]   mv;
        logic [SPEED_W:0]   sum;
        cs   = cur[W-1:2];
        cd   = cur[1:0];
        ts   = target[W-1:2];
        td   = target[1:0];
        diff = '0;
        mv   = '0;
        sum  = '0;
        ramp = cur;
        if (cd == td) begin
            if (cs < ts) begin
                diff = {1'b0, ts} - {1'b0, cs};
                mv   = (step < diff) ? step : diff;
                sum  = {1'b0, cs} + mv;
            end else begin
                diff = {1'b0, cs} - {1'b0, ts};
                mv   = (step < diff) ? step : diff;
                sum  = {1'b0, cs} - mv;
            end
            ramp = {SPEED_W'(sum), cd};
        end else if (cd == NEUTRAL) begin
            ramp = {ONES, td};
        end else if (cs != ONES) begin
            sum = {1'b0, cs} + step;
            if (sum > {1'b0, ONES}) begin
                sum = {1'b0, ONES};
            end
            ramp = {SPEED_W'(sum), cd};
        end else begin
            ramp = {cs, NEUTRAL};
        end
    endfunction

    assign desired = DESIRED_MC;
    assign MCP     = mcp_q;
    assign wrap    = (cnt == CNT_MAX);

    // Effective target, next word and settle flag per channel.
    always_comb begin
        tgt      = '0;
        nxt      = '0;
        stl      = '0;
        step_sel = ESTOP ? STEP_E : STEP_N;
        for (int i = 0; i < int'(N_CH); i++) begin
            tgt[i] = ESTOP ? REST : desired[i];
            nxt[i] = ramp(mcp_q[i], tgt[i], step_sel);
            stl[i] = (mcp_q[i] == tgt[i]) ||
                     ((mcp_q[i][1:0] == NEUTRAL) && (tgt[i][1:0] == NEUTRAL));
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt     <= '0;
            TICK    <= 1'b0;
            SETTLED <= '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                mcp_q[i] <= REST;
            end
        end else begin
            cnt     <= wrap ? '0 : cnt + CNT_W'(1);
            TICK    <= wrap;
            SETTLED <= stl;
            if (wrap) begin
                mcp_q <= nxt;
            end
        end
    end

endmodule

// File: tb/tb_accel_ramp_multi.sv
// Directed bench for accel_ramp_multi (2 channels, 3-bit speed, tick every 4 cycles).
module tb_accel_ramp_multi;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [9:0]  DESIRED_MC;
    logic        ESTOP;
    logic [9:0]  MCP;
    logic [1:0]  SETTLED;
    logic        TICK;

    int n_pass  = 0;
    int n_total = 0;

    accel_ramp_multi #(
        .N_CH(2), .SPEED_W(3), .TICK_DIV(4), .STEP(1), .STEP_ESTOP(2)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .DESIRED_MC(DESIRED_MC), .ESTOP(ESTOP),
        .MCP(MCP), .SETTLED(SETTLED), .TICK(TICK)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    logic [4:0] up0   [7]  = '{5'b11010, 5'b10110, 5'b10010, 5'b01110, 5'b01010, 5'b00110, 5'b00010};
    logic [4:0] rev0  [10] = '{5'b10110, 5'b11010, 5'b11110, 5'b11101, 5'b11100,
                               5'b11000, 5'b10100, 5'b10000, 5'b01100, 5'b01000};
    logic [4:0] up1   [3]  = '{5'b11100, 5'b11000, 5'b10100};
    logic [4:0] mid0  [3]  = '{5'b00110, 5'b01010, 5'b01110};

    initial begin
        RST_N      = 1'b0;
        ESTOP      = 1'b0;
        DESIRED_MC = {5'b11101, 5'b11101};
        step(3);
        chk("rst_mcp", 32'(MCP), 32'({5'b11101, 5'b11101}));
        chk("rst_settled", 32'(SETTLED), 32'(2'b00));
        chk("rst_tick", 32'(TICK), 32'(1'b0));

        // Accelerate ch0 forward to full speed from rest.
        DESIRED_MC = {5'b11101, 5'b00010};
        RST_N      = 1'b1;
        step(1);
        chk("first_no_tick", 32'(TICK), 32'(1'b0));
        chk("first_settled", 32'(SETTLED), 32'(2'b10));
        chk("first_mcp_hold", 32'(MCP), 32'({5'b11101, 5'b11101}));
        step(3);
        chk("tick1", 32'(TICK), 32'(1'b1));
        chk("engage0", 32'(MCP[4:0]), 32'(5'b11110));
        step(1);
        chk("tick1_pulse", 32'(TICK), 32'(1'b0));
        step(3);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) step(4);
            chk($sformatf("accel0_%0d", k), 32'(MCP[4:0]), 32'(up0[k]));
        end
        chk("accel_settled_lat", 32'(SETTLED[0]), 32'(1'b0));
        step(1);
        chk("accel_settled", 32'(SETTLED[0]), 32'(1'b1));

        // Transient target between ticks must not move the output.
        DESIRED_MC = {5'b11101, 5'b11111};
        step(1);
        chk("transient_mcp", 32'(MCP[4:0]), 32'(5'b00010));
        chk("transient_settled", 32'(SETTLED[0]), 32'(1'b0));
        DESIRED_MC = {5'b11101, 5'b00010};
        step(1);
        chk("restored_settled", 32'(SETTLED[0]), 32'(1'b1));
        step(1);
        chk("transient_tick", 32'(TICK), 32'(1'b1));
        chk("transient_after_tick", 32'(MCP[4:0]), 32'(5'b00010));

        // Decelerate to 011, then a single step to 100 without overshoot.
        DESIRED_MC = {5'b11101, 5'b01110};
        for (int k = 0; k < 3; k++) begin
            step(4);
            chk($sformatf("decel0_%0d", k), 32'(MCP[4:0]), 32'(mid0[k]));
        end
        DESIRED_MC = {5'b11101, 5'b10010};
        step(4);
        chk("single_step", 32'(MCP[4:0]), 32'(5'b10010));
        chk("single_settled_lat", 32'(SETTLED[0]), 32'(1'b0));
        step(1);
        chk("single_settled", 32'(SETTLED[0]), 32'(1'b1));
        step(3);
        chk("no_overshoot", 32'(MCP[4:0]), 32'(5'b10010));

        // Reversal: decelerate, neutral, engage at rest, accelerate.
        DESIRED_MC = {5'b11101, 5'b01000};
        for (int k = 0; k < 10; k++) begin
            step(4);
            chk($sformatf("reverse0_%0d", k), 32'(MCP[4:0]), 32'(rev0[k]));
        end

        // Bring ch1 up in direction 00 while ch0 holds.
        DESIRED_MC = {5'b10100, 5'b01000};
        for (int k = 0; k < 3; k++) begin
            step(4);
            chk($sformatf("ch1_%0d", k), 32'(MCP), 32'({up1[k], 5'b01000}));
        end

        // Emergency stop: both channels decelerate by 2 and go neutral.
        ESTOP = 1'b1;
        step(4);
        chk("estop_1", 32'(MCP), 32'({5'b11100, 5'b10000}));
        step(4);
        chk("estop_2", 32'(MCP), 32'({5'b11101, 5'b11000}));
        step(1);
        chk("estop_settled_part", 32'(SETTLED), 32'(2'b10));
        step(3);
        chk("estop_3", 32'(MCP), 32'({5'b11101, 5'b11100}));
        step(4);
        chk("estop_4", 32'(MCP), 32'({5'b11101, 5'b11101}));
        step(1);
        chk("estop_settled_all", 32'(SETTLED), 32'(2'b11));
        ESTOP = 1'b0;
        step(3);
        chk("estop_resume", 32'(MCP), 32'({5'b11100, 5'b11100}));

        // Reset mid-ramp discards state and restarts the prescaler.
        step(2);
        RST_N = 1'b0;
        step(1);
        chk("midrst_mcp", 32'(MCP), 32'({5'b11101, 5'b11101}));
        chk("midrst_tick", 32'(TICK), 32'(1'b0));
        chk("midrst_settled", 32'(SETTLED), 32'(2'b00));
        RST_N = 1'b1;
        step(3);
        chk("midrst_no_tick", 32'(TICK), 32'(1'b0));
        chk("midrst_hold", 32'(MCP), 32'({5'b11101, 5'b11101}));
        step(1);
        chk("midrst_tick4", 32'(TICK), 32'(1'b1));
        chk("midrst_engage", 32'(MCP), 32'({5'b11100, 5'b11100}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
